// File: rtl/linkup_pkg.sv
// Shared types and constants for the host-side link-up sequencer.
package linkup_pkg;

  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_UP      = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

endpackage

// File: rtl/linkup_sync2.sv
// Generic two-flop synchroniser for asynchronous ICH handshake inputs.
module linkup_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/linkup_initiator.sv
// Link-up request sequencer: pulse request, wait for ICH ack, back off and retry, declare failure.
module linkup_initiator
  import linkup_pkg::*;
#(
  parameter int unsigned PULSE_W        = 4,
  parameter int unsigned WAIT_CYCLES    = 16,
  parameter int unsigned BACKOFF_CYCLES = 8,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Start,
  input  logic               i_Abort,
  input  logic               i_ich_linkup,
  output logic               o_LinkUp_En,
  output logic               o_Clear_TimeOut,
  output logic               o_Busy,
  output logic               o_Link_Ok,
  output logic               o_Link_Fail,
  output logic               o_Link_Lost,
  output logic [RETRY_W-1:0] o_Retry_Cnt
);

  localparam logic [CNT_W-1:0]   PulseLast   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0]   WaitLast    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BackoffLast = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RetryMax    = RETRY_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               en_q, en_d;
  logic               clr_q, clr_d;
  logic               busy_q, busy_d;
  logic               ok_q, ok_d;
  logic               fail_q, fail_d;
  logic               lost_q, lost_d;
  logic               ack;

  linkup_sync2 #(
    .Width(1)
  ) u_ack_sync (
    .clk_i (i_Clk),
    .rst_ni(i_Rst_n),
    .d_i   (i_ich_linkup),
    .q_o   (ack)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    if (i_Abort) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          retry_d = '0;
          if (i_Start) state_d = ST_REQ;
        end
        ST_REQ: if (cnt_q == PulseLast) state_d = ST_WAIT;
        ST_WAIT: begin
          // A late ack beats the timeout decided on the same cycle.
          if (ack) begin
            state_d = ST_UP;
          end else if (cnt_q == WaitLast) begin
            if (retry_q == RetryMax) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_BACKOFF;
            end
          end
        end
        ST_BACKOFF: if (cnt_q == BackoffLast) state_d = ST_REQ;
        ST_UP: begin
          if (!ack) begin
            state_d = ST_BACKOFF;
            retry_d = '0;
            lost_d  = 1'b1;
          end
        end
        ST_FAIL: begin
          if (i_Start) begin
            state_d = ST_REQ;
            retry_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Phase counter only runs in timed states so it can never wrap while parked.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_REQ || state_q == ST_WAIT || state_q == ST_BACKOFF) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    en_d   = (state_d == ST_REQ);
    busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_BACKOFF);
    ok_d   = (state_d == ST_UP);
    fail_d = (state_d == ST_FAIL);
    clr_d  = (state_d == ST_BACKOFF) && (state_q != ST_BACKOFF);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
      lost_q  <= lost_d;
    end
  end

  assign o_LinkUp_En     = en_q;
  assign o_Clear_TimeOut = clr_q;
  assign o_Busy          = busy_q;
  assign o_Link_Ok       = ok_q;
  assign o_Link_Fail     = fail_q;
  assign o_Link_Lost     = lost_q;
  assign o_Retry_Cnt     = retry_q;

endmodule

// File: tb/tb_linkup_initiator.sv
// Bench for linkup_initiator: directed sweeps plus random traffic against a phase/countdown model.
module tb_linkup_initiator;

  localparam int PULSE_W        = 4;
  localparam int WAIT_CYCLES    = 16;
  localparam int BACKOFF_CYCLES = 8;
  localparam int MAX_RETRY      = 3;

  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_BACKOFF = 3, P_UP = 4, P_FAIL = 5;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n = 1'b1;
  logic       i_Start = 1'b0;
  logic       i_Abort = 1'b0;
  logic       i_ich_linkup = 1'b0;
  logic       o_LinkUp_En, o_Clear_TimeOut, o_Busy, o_Link_Ok, o_Link_Fail, o_Link_Lost;
  logic [3:0] o_Retry_Cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current phase plus cycles remaining in it; ack seen through a two-deep history.
  int         ph, rem;
  bit         s1, s2;
  logic [3:0] m_retry;
  bit         e_en, e_busy, e_ok, e_fail, e_clr, e_lost;

  linkup_initiator #(
    .PULSE_W       (PULSE_W),
    .WAIT_CYCLES   (WAIT_CYCLES),
    .BACKOFF_CYCLES(BACKOFF_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .CNT_W         (16)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_n        (i_Rst_n),
    .i_Start        (i_Start),
    .i_Abort        (i_Abort),
    .i_ich_linkup   (i_ich_linkup),
    .o_LinkUp_En    (o_LinkUp_En),
    .o_Clear_TimeOut(o_Clear_TimeOut),
    .o_Busy         (o_Busy),
    .o_Link_Ok      (o_Link_Ok),
    .o_Link_Fail    (o_Link_Fail),
    .o_Link_Lost    (o_Link_Lost),
    .o_Retry_Cnt    (o_Retry_Cnt)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; rem = 0; s1 = 0; s2 = 0; m_retry = '0;
    e_en = 0; e_busy = 0; e_ok = 0; e_fail = 0; e_clr = 0; e_lost = 0;
  endtask

  task automatic model_step();
    bit ack;
    ack   = s2;
    s2    = s1;
    s1    = i_ich_linkup;
    e_clr = 0;
    e_lost = 0;
    if (i_Abort) begin
      ph = P_IDLE;
      m_retry = '0;
    end else begin
      case (ph)
        P_IDLE: if (i_Start) begin ph = P_REQ; rem = PULSE_W; m_retry = '0; end
        P_REQ: if (rem == 1) begin ph = P_WAIT; rem = WAIT_CYCLES; end else rem--;
        P_WAIT: begin
          if (ack) ph = P_UP;
          else if (rem == 1) begin
            if (m_retry == MAX_RETRY) ph = P_FAIL;
            else begin
              m_retry++;
              ph = P_BACKOFF; rem = BACKOFF_CYCLES; e_clr = 1;
            end
          end else rem--;
        end
        P_BACKOFF: if (rem == 1) begin ph = P_REQ; rem = PULSE_W; end else rem--;
        P_UP: if (!ack) begin
          ph = P_BACKOFF; rem = BACKOFF_CYCLES; e_clr = 1; e_lost = 1; m_retry = '0;
        end
        P_FAIL: if (i_Start) begin ph = P_REQ; rem = PULSE_W; m_retry = '0; end
        default: ph = P_IDLE;
      endcase
    end
    e_en   = (ph == P_REQ);
    e_busy = (ph == P_REQ) || (ph == P_WAIT) || (ph == P_BACKOFF);
    e_ok   = (ph == P_UP);
    e_fail = (ph == P_FAIL);
  endtask

  task automatic check_outputs(input string pfx);
    check_eq({pfx, ".en"},    {7'd0, o_LinkUp_En},     {7'd0, e_en});
    check_eq({pfx, ".clr"},   {7'd0, o_Clear_TimeOut}, {7'd0, e_clr});
    check_eq({pfx, ".busy"},  {7'd0, o_Busy},          {7'd0, e_busy});
    check_eq({pfx, ".ok"},    {7'd0, o_Link_Ok},       {7'd0, e_ok});
    check_eq({pfx, ".fail"},  {7'd0, o_Link_Fail},     {7'd0, e_fail});
    check_eq({pfx, ".lost"},  {7'd0, o_Link_Lost},     {7'd0, e_lost});
    check_eq({pfx, ".retry"}, {4'd0, o_Retry_Cnt},     {4'd0, m_retry});
  endtask

  // Inputs are changed only after the negedge check, so both DUT and model see them stable.
  task automatic cycle(input string pfx);
    @(posedge i_Clk);
    model_step();
    @(negedge i_Clk);
    check_outputs(pfx);
  endtask

  task automatic async_reset(input string pfx);
    i_Rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(pfx);
    @(negedge i_Clk);
    check_outputs(pfx);
    i_Rst_n = 1'b1;
  endtask

  initial begin
    int tog;
    model_reset();
    #2;
    async_reset("reset");
    i_Start = 1'b0;

    // Sweep the ack rise across REQ, WAIT and the final WAIT cycle.
    for (int d = 0; d < 24; d++) begin
      i_Start = 1'b1;
      cycle("sweep");
      i_Start = 1'b0;
      for (int k = 0; k < d; k++) cycle("sweep");
      i_ich_linkup = 1'b1;
      for (int k = 0; k < 12; k++) cycle("sweep");
      i_ich_linkup = 1'b0;
      for (int k = 0; k < 14; k++) cycle("sweep");
      i_Abort = 1'b1;
      cycle("sweep");
      i_Abort = 1'b0;
    end

    // Full retry exhaustion into FAIL, then restart from FAIL.
    i_Start = 1'b1;
    cycle("fail");
    i_Start = 1'b0;
    for (int k = 0; k < 4 * (PULSE_W + WAIT_CYCLES) + 3 * BACKOFF_CYCLES + 4; k++) cycle("fail");
    check_eq("fail.sticky", {7'd0, o_Link_Fail}, 8'd1);
    check_eq("fail.retry", {4'd0, o_Retry_Cnt}, MAX_RETRY[7:0]);
    i_Start = 1'b1;
    cycle("restart");
    i_Start = 1'b0;
    check_eq("restart.en", {7'd0, o_LinkUp_En}, 8'd1);
    check_eq("restart.retry", {4'd0, o_Retry_Cnt}, 8'd0);

    // Abort at REQ cycle 2 and mid-BACKOFF; async reset mid-WAIT.
    for (int k = 0; k < 2; k++) cycle("abort_req");
    i_Abort = 1'b1;
    cycle("abort_req");
    i_Abort = 1'b0;
    i_Start = 1'b1;
    cycle("abort_bo");
    i_Start = 1'b0;
    for (int k = 0; k < PULSE_W + WAIT_CYCLES + 3; k++) cycle("abort_bo");
    i_Abort = 1'b1;
    cycle("abort_bo");
    i_Abort = 1'b0;
    i_Start = 1'b1;
    cycle("rst_wait");
    i_Start = 1'b0;
    for (int k = 0; k < PULSE_W + 6; k++) cycle("rst_wait");
    async_reset("rst_wait");

    // Random traffic with alternating slow and fast ack activity.
    tog = 20;
    for (int c = 0; c < 6000; c++) begin
      if (c % 400 == 0) tog = ($urandom_range(0, 1) == 0) ? 15 : 250;
      i_Start = ($urandom_range(0, 7) == 0);
      i_Abort = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, tog) == 0) i_ich_linkup = ~i_ich_linkup;
      if ($urandom_range(0, 999) == 0) async_reset("rand_rst");
      else cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/linkup_initiator.md
Name: linkup_initiator

Overview:
- Host-side link-up sequencer. It drives the link-up request towards the ICH and waits for the ICH link-up acknowledge.
- On no acknowledge within a window, it backs off and retries; after a fixed number of retries it declares failure.
- Pairs with the link-up timeout monitor: the request pulse feeds the monitor's enable, and the backoff clear feeds the monitor's clear-timeout input.

Parameters:
- PULSE_W, 4: cycles o_LinkUp_En is held high per request (1..2^CNT_W-1).
- WAIT_CYCLES, 16: cycles to wait for acknowledge after the request pulse ends (1..2^CNT_W-1).
- BACKOFF_CYCLES, 8: idle cycles between a failed attempt and the next request (1..2^CNT_W-1).
- MAX_RETRY, 3: retries allowed after the first attempt (0..15).
- CNT_W, 16: width of the shared phase counter.

Ports:
- i_Clk, input, 1: system clock.
- i_Rst_n, input, 1: asynchronous active-low reset.
- i_Start, input, 1: begin a link-up sequence; level, sampled in IDLE or FAIL.
- i_Abort, input, 1: return to IDLE from any state; has priority over all other inputs.
- i_ich_linkup, input, 1: ICH link-up acknowledge; asynchronous; synchronised internally.
- o_LinkUp_En, output, 1: link-up request to the ICH / monitor.
- o_Clear_TimeOut, output, 1: one-cycle pulse clearing the monitor timeout.
- o_Busy, output, 1: high in REQ, WAIT, BACKOFF.
- o_Link_Ok, output, 1: high in UP.
- o_Link_Fail, output, 1: sticky high in FAIL.
- o_Link_Lost, output, 1: one-cycle pulse when an established link drops.
- o_Retry_Cnt, output, 4: retries consumed in the current sequence.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, both synchroniser flops 0. Reset can arrive in any state; the block returns to IDLE with no pulses emitted.
- Synchroniser: i_ich_linkup passes through a 2-flop synchroniser; `ack` denotes the second flop. All outputs are registered.
- IDLE:
  - i_Start=1 -> REQ.
  - o_LinkUp_En goes high the cycle after i_Start is sampled.
  - o_Retry_Cnt cleared to 0.
- REQ:
  - o_LinkUp_En=1 for exactly PULSE_W cycles; counter counts 0..PULSE_W-1.
  - At the end -> WAIT with the counter reset.
  - ack observed here is ignored; it is re-evaluated in WAIT.
- WAIT:
  - o_LinkUp_En=0.
  - ack=1 -> UP. o_Link_Ok rises 3 cycles after an i_ich_linkup rising edge (2 sync + 1 register).
  - Counter reaching WAIT_CYCLES-1 with ack=0:
    - if o_Retry_Cnt == MAX_RETRY -> FAIL;
    - else o_Retry_Cnt increments -> BACKOFF.
  - If ack and timeout occur in the same cycle, ack wins -> UP.
- BACKOFF:
  - o_Clear_TimeOut=1 on the first cycle only.
  - Stay BACKOFF_CYCLES cycles, then -> REQ.
  - ack ignored.
- UP:
  - o_Link_Ok=1.
  - ack falling -> o_Link_Lost pulses 1 cycle, o_Retry_Cnt cleared to 0 -> BACKOFF (automatic re-link).
- FAIL:
  - o_Link_Fail=1, o_Busy=0, o_Retry_Cnt holds its final value.
  - i_Start=1 -> REQ, with o_Retry_Cnt and o_Link_Fail cleared on entry.
- i_Abort=1 in any state:
  - next state IDLE; o_LinkUp_En, o_Busy, o_Link_Ok, o_Link_Fail cleared next cycle;
  - no o_Clear_TimeOut or o_Link_Lost pulse is generated;
  - o_Retry_Cnt cleared.
- i_Start in REQ, WAIT, BACKOFF or UP: ignored.
- Counter arithmetic:
  - a single CNT_W-bit phase counter, reset to 0 on every state change;
  - compares use terminal value minus 1;
  - no wrap-around in legal parameter ranges.
- o_Retry_Cnt saturates at MAX_RETRY and never wraps.

Decomposition:
- Package linkup_pkg:
  - state encoding constants ST_IDLE, ST_REQ, ST_WAIT, ST_BACKOFF, ST_UP, ST_FAIL (3-bit);
  - RETRY_W=4.
- Sub-module linkup_sync2: generic 2-flop synchroniser with async active-low reset, reused for other ICH handshakes.
- FSM, phase counter and retry counter stay in the top module.

Test Plan:
1. Reset then i_Start pulse, ack raised 5 cycles after o_LinkUp_En falls -> o_LinkUp_En high 4 cycles; o_Link_Ok=1 at 3 cycles after the ack edge; o_Retry_Cnt=0; no o_Clear_TimeOut.
2. i_Start, ack never asserted -> 4 attempts (1+MAX_RETRY):
   - o_Clear_TimeOut pulses 3 times, each followed by 8 cycles of backoff;
   - o_Retry_Cnt steps 1,2,3;
   - FAIL entered 16 cycles after the 4th request ends; o_Link_Fail=1.
3. From FAIL assert i_Start -> o_Link_Fail=0, o_Retry_Cnt=0, new 4-cycle request pulse.
4. Link UP, then drop i_ich_linkup -> o_Link_Lost one-cycle pulse 3 cycles after the drop, o_Link_Ok=0, o_Clear_TimeOut pulse, new request after 8 cycles.
5. Ack edge timed so sync output rises on the final WAIT cycle -> UP, not BACKOFF; o_Retry_Cnt unchanged.
6. i_Abort mid-REQ (cycle 2), and separately mid-BACKOFF; plus i_Rst_n low mid-WAIT -> IDLE with all outputs 0 next cycle (reset: immediately), no stray pulses.
